yuv422_packer: RTL and testbench
================================

YUV422_PACKER -- requirements
Module: yuv422_packer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, output word FIFO depth; legal values 2 or 4.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL provide port yuv_valid  input  1  byte strobe from the colour-transform engine's out_valid.
REQ-005 SHALL provide port yuv_in  input  8  byte stream in order U, Y0, V, Y1; U/V two's complement, Y unsigned.
REQ-006 SHALL provide port sync_clr  input  1  line/frame start; realigns the byte phase to U.
REQ-007 SHALL provide port word_ready  input  1  downstream accepts the head word.
REQ-008 SHALL provide port word_valid  output  1  FIFO non-empty; word_out is valid.
REQ-009 SHALL provide port word_out  output  32  packed word {U[31:24], Y0[23:16], V[15:8], Y1[7:0]}.
REQ-010 SHALL provide port fifo_level  output  3  words held, 0..FIFO_DEPTH.
REQ-011 SHALL provide port overflow  output  1  sticky flag: a complete word was dropped.
REQ-012 SHALL provide port word_cnt  output  16  count of words pushed into the FIFO; wraps 0xFFFF->0x0000.

Function
REQ-013 SHALL keep a 2-bit phase counter: 0=U, 1=Y0, 2=V, 3=Y1.
REQ-014 SHALL, on an edge with yuv_valid=1, store yuv_in in the lane selected by phase and advance phase modulo 4.
REQ-015 SHALL ignore yuv_in when yuv_valid=0; phase and partial lanes hold.
REQ-016 SHALL, on the edge accepting the phase-3 byte, push the assembled word (including that byte) into the FIFO.
REQ-017 SHALL make a pushed word visible as the head on word_out with word_valid=1 in the cycle after the push edge when the FIFO was empty (latency 1 cycle from Y1 byte edge).
REQ-018 SHALL pop the head on an edge where word_valid=1 and word_ready=1; word_ready is ignored while empty.
REQ-019 SHALL drive word_out=32'h0 whenever word_valid=0.
REQ-020 SHALL deliver words in push order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL, on push and pop in the same edge, perform both; fifo_level unchanged; allowed when full (pop frees the slot) and when empty (pop not performed, push performed).
REQ-022 SHALL, on push when full without a simultaneous pop, drop the new word, set overflow=1, keep fifo_level=FIFO_DEPTH and FIFO contents, and leave word_cnt unchanged; phase still wraps to 0.
REQ-023 SHALL clear overflow only by reset.
REQ-024 SHALL increment word_cnt by 1 for each word actually written into the FIFO.
REQ-025 SHALL, on sync_clr=1, discard any partial word and set phase to 0; if yuv_valid=1 in the same edge, that byte is stored as U and phase becomes 1.
REQ-026 SHALL leave FIFO contents, fifo_level, overflow and word_cnt unaffected by sync_clr.
REQ-027 SHALL treat all bytes as raw 8-bit values; no sign extension, saturation or rounding.

Reset
REQ-028 SHALL, on any edge with reset=0, set phase=0, clear partial lanes, empty the FIFO, and drive word_valid=0, word_out=0, fifo_level=0, overflow=0, word_cnt=0.
REQ-029 SHALL give reset priority over yuv_valid, sync_clr and word_ready in the same edge.
REQ-030 SHALL, on reset asserted mid-word, discard the partial word; the first 4 valid bytes after release form the next word.

Verification
REQ-031 Reset: reset=0 for 2 cycles with yuv_valid=1 -> word_valid=0, word_out=0, fifo_level=0, overflow=0, word_cnt=0.
REQ-032 Basic pack: word_ready=1, bytes 0x10,0x80,0xF0,0x82 on consecutive cycles -> word_out=0x1080F082, word_valid=1 for exactly 1 cycle after the 4th byte edge; word_cnt=1.
REQ-033 Backpressure/overflow: word_ready=0, 5 words 0x00000001..0x00000005 -> fifo_level=4, overflow=1, word_cnt=4; then word_ready=1 -> 0x00000001..0x00000004 in order, fifo_level returns to 0, overflow stays 1.
REQ-034 Full with simultaneous pop/push: FIFO full, word_ready=1 on Y1 edge of word 0xA5A5A5A5 -> fifo_level stays 4, overflow=0, 0xA5A5A5A5 emerges last.
REQ-035 Realign: bytes 0x11,0x22, then sync_clr=1 with yuv_valid=1 byte 0xA1, then 0xA2,0xA3,0xA4 -> single word 0xA1A2A3A4; 0x11/0x22 never appear.
REQ-036 Reset mid-word: bytes 0x01,0x02,0x03, reset=0 one cycle, then 0x0A,0x0B,0x0C,0x0D -> single word 0x0A0B0C0D, word_cnt=1.

Source files
------------

// File: rtl/yuv422_packer.sv
// Packs a U,Y0,V,Y1 byte stream into 32-bit words and buffers them in a small
// FIFO. The FIFO accepts a push while full if the same edge also pops.
module yuv422_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        yuv_valid,
  input  logic [7:0]  yuv_in,
  input  logic        sync_clr,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic [2:0]  fifo_level,
  output logic        overflow,
  output logic [15:0] word_cnt
);

  localparam logic [1:0] PH_U  = 2'd0;
  localparam logic [1:0] PH_Y0 = 2'd1;
  localparam logic [1:0] PH_V  = 2'd2;
  localparam logic [1:0] PH_Y1 = 2'd3;

  localparam int            PW       = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [2:0]    FULL_LVL = 3'(FIFO_DEPTH);

  logic [1:0]    phase;
  logic [1:0]    phase_eff;
  logic [7:0]    lane_u;
  logic [7:0]    lane_y0;
  logic [7:0]    lane_v;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    level;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;

  // sync_clr realigns in the same edge, so a byte arriving with it is a U byte.
  assign phase_eff = sync_clr ? PH_U : phase;
  assign empty     = (level == 3'd0);
  assign full      = (level == FULL_LVL);
  assign push      = yuv_valid && (phase_eff == PH_Y1);
  assign pop       = !empty && word_ready;
  assign wr_en     = push && (!full || pop);

  assign word_valid = !empty;
  assign word_out   = empty ? 32'h0 : mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase     <= PH_U;
      lane_u    <= 8'h0;
      lane_y0   <= 8'h0;
      lane_v    <= 8'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= 3'd0;
      overflow  <= 1'b0;
      word_cnt  <= 16'h0;
    end else begin
      if (sync_clr) begin
        phase   <= PH_U;
        lane_u  <= 8'h0;
        lane_y0 <= 8'h0;
        lane_v  <= 8'h0;
      end
      if (yuv_valid) begin
        phase <= phase_eff + 2'd1;
        case (phase_eff)
          PH_U:    lane_u  <= yuv_in;
          PH_Y0:   lane_y0 <= yuv_in;
          PH_V:    lane_v  <= yuv_in;
          PH_Y1:   ;
          default: ;
        endcase
      end

      if (wr_en) begin
        wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        word_cnt <= word_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end

      case ({wr_en, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase

      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_ptr] <= {lane_u, lane_y0, lane_v, yuv_in};
    end
  end

endmodule

// File: tb/tb_yuv422_packer.sv
// Self-checking bench for yuv422_packer: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based reference model.
module tb_yuv422_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        yuv_valid = 1'b0;
  logic [7:0]  yuv_in = 8'h0;
  logic        sync_clr = 1'b0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [31:0] word_out;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Reference model state
  logic [7:0]  part[$];
  logic [31:0] fq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  yuv422_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .yuv_valid  (yuv_valid),
    .yuv_in     (yuv_in),
    .sync_clr   (sync_clr),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_out   (word_out),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // Drive one clock edge of stimulus and advance the model with the same inputs.
  task automatic drive(input logic v, input logic [7:0] b, input logic c,
                       input logic r, input logic rst_n);
    logic        have_w;
    logic        do_pop;
    logic [31:0] w;
    yuv_valid  = v;
    yuv_in     = b;
    sync_clr   = c;
    word_ready = r;
    reset      = rst_n;
    @(posedge clk);
    have_w = 1'b0;
    w      = 32'h0;
    if (!rst_n) begin
      part.delete();
      fq.delete();
      m_ovf = 1'b0;
      m_cnt = 16'h0;
    end else begin
      do_pop = (fq.size() != 0) && r;
      if (c) part.delete();
      if (v) begin
        part.push_back(b);
        if (part.size() == 4) begin
          w = {part[0], part[1], part[2], part[3]};
          part.delete();
          have_w = 1'b1;
        end
      end
      if (do_pop) begin
        if (verbose) $display("pop  word %08h", fq[0]);
        void'(fq.pop_front());
      end
      if (have_w) begin
        if (fq.size() < DEPTH) begin
          fq.push_back(w);
          m_cnt = m_cnt + 16'd1;
          if (verbose) $display("push word %08h", w);
        end else begin
          m_ovf = 1'b1;
          if (verbose) $display("drop word %08h", w);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 8'h00, 1'b0, r, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic r);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i*8 +: 8], 1'b0, r, 1'b1);
  endtask

  task automatic test_reset();
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    n_checks += 5;
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    if (word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word got %08h exp 0", word_out); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
  endtask

  task automatic test_basic_pack();
    do_reset();
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'hF0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL pack_early_valid got %b exp 0", word_valid); end
    drive(1'b1, 8'h82, 1'b0, 1'b1, 1'b1);
    n_checks += 3;
    if (word_valid !== 1'b1) begin n_fail++; $display("FAIL pack_valid got %b exp 1", word_valid); end
    if (word_out !== 32'h1080F082) begin n_fail++; $display("FAIL pack_word got %08h exp 1080f082", word_out); end
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL pack_cnt got %0d exp 1", word_cnt); end
    idle(1'b1);
    n_checks += 2;
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL pack_one_cycle got %b exp 0", word_valid); end
    if (word_out !== 32'h0) begin n_fail++; $display("FAIL pack_zero_out got %08h exp 0", word_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 5; k++) send_word(32'(k), 1'b0);
    n_checks += 3;
    if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    if (word_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 4", word_cnt); end
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (word_out !== 32'(k)) begin n_fail++; $display("FAIL ovf_order[%0d] got %08h exp %08h", k, word_out, 32'(k)); end
      idle(1'b1);
    end
    n_checks += 3;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained got %0d exp 0", fifo_level); end
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_valid got %b exp 0", word_valid); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_words [4];
    exp_words = '{32'h12, 32'h13, 32'h14, 32'hA5A5A5A5};
    do_reset();
    for (int k = 1; k <= 4; k++) send_word(32'h10 + 32'(k), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    n_checks += 3;
    if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level got %0d exp 4", fifo_level); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
    if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL fpp_cnt got %0d exp 5", word_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (word_out !== exp_words[k]) begin n_fail++; $display("FAIL fpp_order[%0d] got %08h exp %08h", k, word_out, exp_words[k]); end
      idle(1'b1);
    end
  endtask

  task automatic test_realign();
    do_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hA1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL realign_early got %0d exp 0", fifo_level); end
    drive(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1);
    n_checks += 3;
    if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL realign_level got %0d exp 1", fifo_level); end
    if (word_out !== 32'hA1A2A3A4) begin n_fail++; $display("FAIL realign_word got %08h exp a1a2a3a4", word_out); end
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL realign_cnt got %0d exp 1", word_cnt); end
    idle(1'b1);
  endtask

  task automatic test_reset_midword();
    do_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
    n_checks += 3;
    if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL midrst_level got %0d exp 1", fifo_level); end
    if (word_out !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL midrst_word got %08h exp 0a0b0c0d", word_out); end
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_cnt got %0d exp 1", word_cnt); end
    idle(1'b1);
  endtask

  task automatic test_random();
    logic        v, c, r, rst_n;
    logic [31:0] e_out;
    int          fails_here;
    verbose = 1'b0;
    fails_here = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v     = ($urandom_range(0, 3) != 0);
      c     = ($urandom_range(0, 31) == 0);
      // Alternate long stretches of light and heavy backpressure.
      r     = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      drive(v, 8'($urandom), c, r, rst_n);
      e_out = (fq.size() != 0) ? fq[0] : 32'h0;
      n_checks += 5;
      if (word_valid !== (fq.size() != 0)) begin n_fail++; fails_here++;
        if (fails_here < 20) $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, word_valid, fq.size() != 0); end
      if (word_out !== e_out) begin n_fail++; fails_here++;
        if (fails_here < 20) $display("FAIL rand_word cyc %0d got %08h exp %08h", cyc, word_out, e_out); end
      if (fifo_level !== 3'(fq.size())) begin n_fail++; fails_here++;
        if (fails_here < 20) $display("FAIL rand_level cyc %0d got %0d exp %0d", cyc, fifo_level, fq.size()); end
      if (overflow !== m_ovf) begin n_fail++; fails_here++;
        if (fails_here < 20) $display("FAIL rand_ovf cyc %0d got %b exp %b", cyc, overflow, m_ovf); end
      if (word_cnt !== m_cnt) begin n_fail++; fails_here++;
        if (fails_here < 20) $display("FAIL rand_cnt cyc %0d got %0d exp %0d", cyc, word_cnt, m_cnt); end
    end
    verbose = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_overflow();
    test_full_push_pop();
    test_realign();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
